rf_mmio: RTL and testbench
==========================

// Module: rf_mmio
// PURPOSE
//  Parametrised core register file with memory-mapped I/O registers: 2 async read ports, 1 write port,
//  R0 hardwired zero, NUM_IN synchronised input registers and NUM_OUT output registers with write strobes.
//  Adds write-through bypass and a sequenced clear after reset (busy_o). Sits between decode and ALU in the pico core.
// PARAMETERS
//  N           pico::N (8)  data width, bits
//  R           pico::R (32) register count, >= 2; need not be a power of two
//  IN_BASE     4            address of first input register
//  NUM_IN      1            number of input registers, 0..R-2
//  OUT_BASE    8            address of first output register
//  NUM_OUT     1            number of output registers, 0..R-2
//  SYNC_STAGES 2            synchroniser depth on ext_data_i, >= 1
//  BYPASS      1            1: a same-cycle write is visible on the read ports; 0: old value is returned
// PORTS
//  clk_i       in  1             single clock; all state on posedge
//  rst_i       in  1             synchronous, active-high reset
//  wr_en_i     in  1             write enable
//  wr_addr_i   in  $clog2(R)     write address
//  wr_data_i   in  N             write data, signed
//  rs_addr_i   in  $clog2(R)     read port A address
//  rd_addr_i   in  $clog2(R)     read port B address
//  rs_data_o   out N             read port A data, signed, combinational
//  rd_data_o   out N             read port B data, signed, combinational
//  ext_data_i  in  NUM_IN*N      external inputs; slice k maps to IN_BASE+k; may be asynchronous
//  ext_data_o  out NUM_OUT*N     output register contents; slice k = reg OUT_BASE+k
//  ext_stb_o   out NUM_OUT       bit k pulses 1 cycle when ext_data_o slice k is rewritten
//  busy_o      out 1             1 while the clear sequence runs
// BEHAVIOUR
//  Reset/clear FSM, states CLEAR and RUN:
//  - rst_i sampled high: state <= CLEAR, clr_addr <= 0, sync flops <= 0, ext_stb_o <= 0.
//  - CLEAR with rst_i low: regs[clr_addr] <= 0, clr_addr++. After writing R-1, state <= RUN.
//    busy_o = (state == CLEAR), so busy_o is high for exactly R cycles after rst_i falls.
//  - rst_i high mid-clear restarts at clr_addr 0; clr_addr is held while rst_i stays high.
//  - In CLEAR: wr_en_i ignored, ext_stb_o held 0, rs_data_o = rd_data_o = 0.
//    ext_data_o shows the register contents, so slices reach 0 as their addresses are cleared.
//  Register classes (RUN):
//  - Addr 0 reads 0; writes discarded.
//  - Input reg IN_BASE+k: loaded every cycle from the final stage of a SYNC_STAGES synchroniser on slice k.
//    A new ext_data_i value is readable SYNC_STAGES+1 edges after it is applied; core writes discarded.
//  - Output reg OUT_BASE+k: normal read/write. A write updates ext_data_o slice k on the next edge.
//    ext_stb_o[k] is registered, high for the cycle after that edge, and pulses even if the value is unchanged.
//    Back-to-back writes hold ext_stb_o[k] high on consecutive cycles.
//  - Other addresses < R: ordinary registers. Addresses >= R read 0; writes there are ignored.
//  Reads: combinational from addresses.
//  - BYPASS=1: if wr_en_i, the state is RUN, wr_addr == read addr, and that address is writable,
//    the port returns wr_data_i. Both ports bypass independently; reads of addr 0 and input regs never bypass.
//  Elaboration: $error if an I/O range exceeds R-1, includes addr 0, or IN and OUT ranges overlap.
//  Register contents are not reset except through the CLEAR sequence.
// STRUCTURE
//  pico package: N, R, default IN_BASE/OUT_BASE/NUM_IN/NUM_OUT;
//    typedef rf_state_e {CLEAR, RUN}; typedef rf_addr_t = logic [$clog2(R)-1:0].
//  Sub-module sync_vec #(W, STAGES): synchronous-reset flop chain, one instance per input register.
//  Also in this file: per-address class decode (zero/in/out/plain/invalid), clear FSM + counter,
//    write-enable gating, and bypass muxes.
// TESTING
//  1. rst_i high 3 cycles, then low -> busy_o=1 for exactly 32 cycles, then 0; every address reads 0 afterwards.
//  2. Write 0x5A to r3, read rs=rd=3 in the same cycle -> both 0x5A (BYPASS=1); old value with BYPASS=0; next cycle 0x5A.
//  3. Write 0x7F to r0 and to r4 (input) -> r0 reads 0; r4 keeps the synchronised ext_data_i value.
//  4. ext_data_i: 0x00 -> 0xC3 -> r4 reads 0xC3 exactly 3 edges later (SYNC_STAGES=2); signed view is -61.
//  5. Write 0x11 then 0x11 to r8 on consecutive cycles -> ext_data_o=0x11; ext_stb_o high 2 consecutive cycles.
//  6. Assert rst_i at clr_addr=17, release -> clear restarts at 0; busy_o high 32 further cycles; wr_en_i ignored throughout.

Source files
------------

// File: rtl/rf_mmio_pkg.sv
// Shared constants and types for the pico core register file with memory-mapped I/O.
package rf_mmio_pkg;

  localparam int PICO_N       = 8;
  localparam int PICO_R       = 32;
  localparam int DEF_IN_BASE  = 4;
  localparam int DEF_NUM_IN   = 1;
  localparam int DEF_OUT_BASE = 8;
  localparam int DEF_NUM_OUT  = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  typedef logic [$clog2(PICO_R)-1:0] rf_addr_t;

endpackage

// File: rtl/rf_mmio_sync_vec.sv
// Multi-stage flop chain bringing an asynchronous input vector into the clk domain.
module rf_mmio_sync_vec #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/rf_mmio.sv
// Core register file: R0 = 0, synchronised input registers, strobed output registers,
// write-through bypass and a one-address-per-cycle clear sequence after reset.
//   state | meaning
//   CLEAR | zeroing regs[clr_q], one per cycle; ports read 0, writes ignored
//   RUN   | normal register file operation
module rf_mmio
  import rf_mmio_pkg::*;
#(
  parameter int N           = PICO_N,
  parameter int R           = PICO_R,
  parameter int IN_BASE     = DEF_IN_BASE,
  parameter int NUM_IN      = DEF_NUM_IN,
  parameter int OUT_BASE    = DEF_OUT_BASE,
  parameter int NUM_OUT     = DEF_NUM_OUT,
  parameter int SYNC_STAGES = 2,
  parameter int BYPASS      = 1,
  localparam int AW         = $clog2(R),
  localparam int INW        = (NUM_IN  > 0) ? NUM_IN  * N : N,
  localparam int OUTW       = (NUM_OUT > 0) ? NUM_OUT * N : N,
  localparam int STBW       = (NUM_OUT > 0) ? NUM_OUT : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic signed [N-1:0]  wr_data_i,
  input  logic [AW-1:0]        rs_addr_i,
  input  logic [AW-1:0]        rd_addr_i,
  output logic signed [N-1:0]  rs_data_o,
  output logic signed [N-1:0]  rd_data_o,
  input  logic [INW-1:0]       ext_data_i,
  output logic [OUTW-1:0]      ext_data_o,
  output logic [STBW-1:0]      ext_stb_o,
  output logic                 busy_o
);

  localparam int ASPACE = 1 << AW;

  rf_state_e     state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;
  logic          clr_we;
  logic          we_run;
  logic [N-1:0]  rd_val [ASPACE];
  logic [ASPACE-1:0] wr_ok;
  logic [N-1:0]  sync_q [(NUM_IN > 0) ? NUM_IN : 1];

  if (NUM_IN > 0 && (IN_BASE < 1 || IN_BASE + NUM_IN - 1 > R - 1)) begin : g_bad_in
    $error("rf_mmio: input register range must lie within 1..R-1");
  end
  if (NUM_OUT > 0 && (OUT_BASE < 1 || OUT_BASE + NUM_OUT - 1 > R - 1)) begin : g_bad_out
    $error("rf_mmio: output register range must lie within 1..R-1");
  end
  if (NUM_IN > 0 && NUM_OUT > 0 &&
      IN_BASE < OUT_BASE + NUM_OUT && OUT_BASE < IN_BASE + NUM_IN) begin : g_overlap
    $error("rf_mmio: input and output register ranges overlap");
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == CLEAR) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == AW'(R - 1)) state_d = RUN;
    end
  end

  assign busy_o = (state_q == CLEAR);
  assign clr_we = (state_q == CLEAR) && !rst_i;
  assign we_run = wr_en_i && (state_q == RUN);

  for (genvar k = 0; k < NUM_IN; k++) begin : g_sync
    rf_mmio_sync_vec #(.W(N), .STAGES(SYNC_STAGES)) u_sync (
      .clk (clk_i),
      .rst (rst_i),
      .d   (ext_data_i[k*N +: N]),
      .q   (sync_q[k])
    );
  end

  // One storage slot per address; unused or read-only-zero addresses collapse to constants.
  for (genvar a = 0; a < ASPACE; a++) begin : g_addr
    localparam bit IS_VALID = (a < R);
    localparam bit IS_ZERO  = (a == 0);
    localparam bit IS_IN    = (a >= IN_BASE) && (a < IN_BASE + NUM_IN);

    assign wr_ok[a] = IS_VALID && !IS_ZERO && !IS_IN;

    if (!IS_VALID || IS_ZERO) begin : g_zero
      assign rd_val[a] = '0;
    end else if (IS_IN) begin : g_in
      logic [N-1:0] q;
      always_ff @(posedge clk_i) begin
        if (clr_we && clr_q == AW'(a)) q <= '0;
        else                           q <= sync_q[a - IN_BASE];
      end
      assign rd_val[a] = q;
    end else begin : g_store
      logic [N-1:0] q;
      always_ff @(posedge clk_i) begin
        if (clr_we && clr_q == AW'(a))             q <= '0;
        else if (we_run && wr_addr_i == AW'(a))    q <= wr_data_i;
      end
      assign rd_val[a] = q;
    end
  end

  if (NUM_OUT > 0) begin : g_out
    logic [NUM_OUT-1:0] stb_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stb_q <= '0;
      end else begin
        for (int k = 0; k < NUM_OUT; k++)
          stb_q[k] <= we_run && (wr_addr_i == AW'(OUT_BASE + k));
      end
    end
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slice
      assign ext_data_o[k*N +: N] = rd_val[OUT_BASE + k];
    end
    assign ext_stb_o = stb_q;
  end else begin : g_no_out
    assign ext_data_o = '0;
    assign ext_stb_o  = '0;
  end

  always_comb begin
    rs_data_o = '0;
    rd_data_o = '0;
    if (state_q == RUN) begin
      if (BYPASS != 0 && wr_en_i && wr_addr_i == rs_addr_i && wr_ok[rs_addr_i])
        rs_data_o = wr_data_i;
      else
        rs_data_o = rd_val[rs_addr_i];
      if (BYPASS != 0 && wr_en_i && wr_addr_i == rd_addr_i && wr_ok[rd_addr_i])
        rd_data_o = wr_data_i;
      else
        rd_data_o = rd_val[rd_addr_i];
    end
  end

endmodule

// File: tb/tb_rf_mmio.sv
// Directed bench for rf_mmio: a bypassing and a non-bypassing instance share the same stimulus.
module tb_rf_mmio;
  import rf_mmio_pkg::*;

  localparam int N = 8;
  localparam int R = 32;

  logic              clk = 1'b0;
  logic              rst, wr_en;
  rf_addr_t          wr_addr, rs_addr, rd_addr;
  logic signed [N-1:0] wr_data;
  logic [N-1:0]      ext_in;
  logic signed [N-1:0] rs_data, rd_data, rs_nb, rd_nb;
  logic [N-1:0]      ext_out, ext_out_nb;
  logic [0:0]        ext_stb, ext_stb_nb;
  logic              busy, busy_nb;

  int vectors = 0;
  int miscompares = 0;
  int cnt;
  logic stb_seen;

  always #5 clk = ~clk;

  rf_mmio #(.BYPASS(1)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rs_addr_i(rs_addr), .rd_addr_i(rd_addr), .rs_data_o(rs_data), .rd_data_o(rd_data),
    .ext_data_i(ext_in), .ext_data_o(ext_out), .ext_stb_o(ext_stb), .busy_o(busy)
  );

  rf_mmio #(.BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rs_addr_i(rs_addr), .rd_addr_i(rd_addr), .rs_data_o(rs_nb), .rd_data_o(rd_nb),
    .ext_data_i(ext_in), .ext_data_o(ext_out_nb), .ext_stb_o(ext_stb_nb), .busy_o(busy_nb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic count_busy();
    cnt = 0;
    stb_seen = 1'b0;
    while (busy === 1'b1 && cnt < 100) begin
      step();
      cnt++;
      if (ext_stb !== 1'b0) stb_seen = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = '0; rd_addr = '0; ext_in = 8'h00;

    // reset for 3 cycles, then a full clear with a write attempt held on
    repeat (3) step();
    check("busy_in_reset", busy, 1);
    check("stb_in_reset", ext_stb, 0);
    rst = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h33; rs_addr = 5'd5; rd_addr = 5'd8;
    #1;
    check("rs_in_clear", rs_data, 8'h00);
    check("rd_in_clear", rd_data, 8'h00);
    count_busy();
    check_int("busy_cycles", cnt, 32);
    check("stb_during_clear", stb_seen, 0);
    check("busy_nb_done", busy_nb, 0);
    wr_en = 1'b0;
    for (int a = 0; a < R; a++) begin
      rs_addr = rf_addr_t'(a);
      rd_addr = rf_addr_t'(R - 1 - a);
      #1;
      check("post_clear_rs", rs_data, 8'h00);
      check("post_clear_rd", rd_data, 8'h00);
    end
    check("post_clear_ext", ext_out, 8'h00);

    // same-cycle bypass vs old value
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'h5A; rs_addr = 5'd3; rd_addr = 5'd3;
    #1;
    check("bypass_rs", rs_data, 8'h5A);
    check("bypass_rd", rd_data, 8'h5A);
    check("nobypass_rs", rs_nb, 8'h00);
    check("nobypass_rd", rd_nb, 8'h00);
    step();
    wr_en = 1'b0;
    #1;
    check("r3_after", rs_data, 8'h5A);
    check("r3_after_nb", rd_nb, 8'h5A);

    // writes to r0 and the input register are discarded
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'h7F; rs_addr = 5'd0; rd_addr = 5'd0;
    #1;
    check("r0_no_bypass", rs_data, 8'h00);
    step();
    wr_en = 1'b0;
    #1;
    check("r0_zero", rd_data, 8'h00);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 8'h7F; rs_addr = 5'd4;
    #1;
    check("r4_no_bypass", rs_data, 8'h00);
    step();
    wr_en = 1'b0;
    #1;
    check("r4_write_ignored", rs_data, 8'h00);

    // synchroniser latency: visible after exactly 3 edges
    ext_in = 8'hC3;
    #1;
    check("r4_sync_e0", rs_data, 8'h00);
    step();
    check("r4_sync_e1", rs_data, 8'h00);
    step();
    check("r4_sync_e2", rs_data, 8'h00);
    step();
    check("r4_sync_e3", rs_data, 8'hC3);
    check_int("r4_signed", int'(rs_data), -61);

    // output register strobes on back-to-back equal writes
    rs_addr = 5'd8;
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 8'h11;
    #1;
    check("stb_before", ext_stb, 0);
    check("r8_bypass", rs_data, 8'h11);
    step();
    check("ext_out_w1", ext_out, 8'h11);
    check("stb_w1", ext_stb, 1);
    step();
    wr_en = 1'b0;
    #1;
    check("ext_out_w2", ext_out, 8'h11);
    check("stb_w2", ext_stb, 1);
    step();
    check("stb_end", ext_stb, 0);
    check("ext_out_hold", ext_out, 8'h11);

    // top address is an ordinary register
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 8'h9C; rd_addr = 5'd30;
    step();
    wr_en = 1'b0; rs_addr = 5'd31;
    #1;
    check("r31", rs_data, 8'h9C);
    check("r30", rd_data, 8'h00);
    check("stb_non_out", ext_stb, 0);

    // reset in the middle of clearing restarts the sequence
    rst = 1'b1;
    step();
    rst = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'hEE;
    repeat (17) step();
    check("busy_mid_clear", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    count_busy();
    check_int("busy_restart_cycles", cnt, 32);
    check("stb_restart_clear", stb_seen, 0);
    wr_en = 1'b0; rs_addr = 5'd3; rd_addr = 5'd31;
    #1;
    check("r3_cleared", rs_data, 8'h00);
    check("r31_cleared", rd_data, 8'h00);
    check("ext_out_cleared", ext_out, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
